// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs a single-outstanding
// request/grant/response port to instruction memory and drives the IF/ID bus.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no transaction outstanding; request fetch_pc when skid is empty
// WAIT  | one granted transaction in flight; response dropped if kill set
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          IF_ID_BUS = 64,
   parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall_i,
   input  logic                 br_taken_i,
   input  logic [31:0]          br_target_i,
   output logic                 imem_req,
   output logic [31:0]          imem_addr,
   input  logic                 imem_gnt,
   input  logic                 imem_rvalid,
   input  logic [31:0]          imem_rdata,
   output logic [IF_ID_BUS-1:0] if_id_bus_out
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        kill_q, kill_d;
   logic [31:0] out_inst_q, out_inst_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic        skid_vld_q, skid_vld_d;
   logic [31:0] skid_inst_q, skid_inst_d;
   logic [31:0] skid_pc_q, skid_pc_d;

   logic        granted;
   logic        rsp_fire;
   logic        rsp_take;
   logic        consume;
   logic        pend_after;

   always_comb begin
      imem_req   = (state_q == S_IDLE) && !skid_vld_q && !rst;
      imem_addr  = fetch_pc_q;
      granted    = imem_req && imem_gnt;
      rsp_fire   = (state_q == S_WAIT) && imem_rvalid;
      rsp_take   = rsp_fire && !kill_q;
      consume    = !stall_i;
      // a transaction is still owed to us after this edge
      pend_after = ((state_q == S_WAIT) && !imem_rvalid) || granted;
   end

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      req_pc_d    = req_pc_q;
      kill_d      = kill_q;
      out_inst_d  = out_inst_q;
      out_pc_d    = out_pc_q;
      skid_vld_d  = skid_vld_q;
      skid_inst_d = skid_inst_q;
      skid_pc_d   = skid_pc_q;

      case (state_q)
         S_IDLE: begin
            if (granted) begin
               state_d    = S_WAIT;
               fetch_pc_d = fetch_pc_q + 32'd4;
               req_pc_d   = fetch_pc_q;
            end
         end
         S_WAIT: begin
            if (rsp_fire) begin
               state_d = S_IDLE;
               kill_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (consume) begin
         if (skid_vld_q) begin
            out_inst_d = skid_inst_q;
            out_pc_d   = skid_pc_q;
            skid_vld_d = 1'b0;
            if (rsp_take) begin
               skid_inst_d = imem_rdata;
               skid_pc_d   = req_pc_q;
               skid_vld_d  = 1'b1;
            end
         end else if (rsp_take) begin
            out_inst_d = imem_rdata;
            out_pc_d   = req_pc_q;
         end else begin
            out_inst_d = NOP_INST;
            out_pc_d   = 32'h0;
         end
      end else if (rsp_take) begin
         // output must stay bit-exact under stall, so the response parks in skid
         skid_inst_d = imem_rdata;
         skid_pc_d   = req_pc_q;
         skid_vld_d  = 1'b1;
      end

      if (br_taken_i) begin
         fetch_pc_d = {br_target_i[31:2], 2'b00};
         out_inst_d = NOP_INST;
         out_pc_d   = 32'h0;
         skid_vld_d = 1'b0;
         if (pend_after) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
         end else begin
            state_d = S_IDLE;
            kill_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= pend_after ? S_WAIT : S_IDLE;
         kill_q      <= pend_after;
         fetch_pc_q  <= RESET_PC;
         req_pc_q    <= 32'h0;
         out_inst_q  <= NOP_INST;
         out_pc_q    <= 32'h0;
         skid_vld_q  <= 1'b0;
         skid_inst_q <= 32'h0;
         skid_pc_q   <= 32'h0;
      end else begin
         state_q     <= state_d;
         kill_q      <= kill_d;
         fetch_pc_q  <= fetch_pc_d;
         req_pc_q    <= req_pc_d;
         out_inst_q  <= out_inst_d;
         out_pc_q    <= out_pc_d;
         skid_vld_q  <= skid_vld_d;
         skid_inst_q <= skid_inst_d;
         skid_pc_q   <= skid_pc_d;
      end
   end

   assign if_id_bus_out = {out_inst_q, out_pc_q};

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by randomized stall/redirect
// traffic, checked against a stream-level model of the fetched program order.
module tb_if_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [63:0] BUBBLE   = {NOP, 32'h0};

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        br_taken_i;
   logic [31:0] br_target_i;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [63:0] if_id_bus_out;

   always #5 clk = ~clk;

   if_stage #(.RESET_PC(RESET_PC), .IF_ID_BUS(64), .NOP_INST(NOP)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .br_taken_i    (br_taken_i),
      .br_target_i   (br_target_i),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_gnt      (imem_gnt),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .if_id_bus_out (if_id_bus_out)
   );

   int total = 0;
   int bad   = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   // memory model: one outstanding transaction, configurable grant delay/latency
   int          gnt_delay = 0;
   int          rsp_lat   = 1;
   bit          rand_mem  = 1'b0;
   bit          pend      = 1'b0;
   logic [31:0] pend_addr = 32'h0;
   int          lat_cnt   = 0;
   int          wait_cnt  = 0;

   initial begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      forever begin
         @(negedge clk);
         #1;
         imem_gnt    = 1'b0;
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
         if (pend) begin
            if (lat_cnt <= 1) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(pend_addr);
               pend        = 1'b0;
            end else begin
               lat_cnt--;
            end
         end else if (imem_req === 1'b1) begin
            if (rand_mem ? ($urandom_range(0, 9) < 6) : (wait_cnt >= gnt_delay)) begin
               imem_gnt  = 1'b1;
               pend      = 1'b1;
               pend_addr = imem_addr;
               lat_cnt   = rand_mem ? 1 + int'($urandom_range(0, 3)) : rsp_lat;
               wait_cnt  = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // stream model state
   logic [63:0] prev_bus = 64'h0;
   logic [31:0] exp_pc   = RESET_PC;
   int          consumed = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // one clock; checks the edge just taken against the stream rules
   task automatic cyc();
      logic        a_rst, a_stall, a_br;
      logic [31:0] a_tgt;
      logic [63:0] bus;
      a_rst   = rst;
      a_stall = stall_i;
      a_br    = br_taken_i;
      a_tgt   = br_target_i;
      @(negedge clk);
      bus = if_id_bus_out;
      if (a_rst) begin
         chk("rst_bubble", bus, BUBBLE);
         chk("rst_req", 64'(imem_req), 64'(1'b0));
         exp_pc = RESET_PC;
      end else if (a_br) begin
         chk("br_bubble", bus, BUBBLE);
         exp_pc = {a_tgt[31:2], 2'b00};
      end else if (a_stall) begin
         chk("stall_hold", bus, prev_bus);
      end else if (bus !== BUBBLE) begin
         chk("inst_data", 64'(bus[63:32]), 64'(mem_word(bus[31:0])));
         chk("pc_order", 64'(bus[31:0]), 64'(exp_pc));
         exp_pc = exp_pc + 32'd4;
         consumed++;
      end
      if (imem_req === 1'b1) chk("addr_align", 64'(imem_addr[1:0]), 64'(2'b00));
      prev_bus   = bus;
      br_taken_i = 1'b0;
   endtask

   task automatic wait_req(input logic v, input string tag);
      for (int n = 0; n < 20 && imem_req !== v; n++) cyc();
      chk(tag, 64'(imem_req), 64'(v));
   endtask

   task automatic wait_inst(input logic [31:0] pc, input string tag);
      cyc();
      for (int n = 0; n < 30 && prev_bus === BUBBLE; n++) cyc();
      chk(tag, 64'(prev_bus[31:0]), 64'(pc));
   endtask

   logic [63:0] t1_exp [6];
   logic [31:0] a0;
   int          c0;

   initial begin
      rst         = 1'b1;
      stall_i     = 1'b0;
      br_taken_i  = 1'b0;
      br_target_i = 32'h0;
      repeat (3) cyc();

      // reset release and steady fetch with single-cycle grant
      rst = 1'b0;
      #1;
      chk("first_req", 64'(imem_req), 64'(1'b1));
      chk("first_addr", 64'(imem_addr), 64'(RESET_PC));
      t1_exp[0] = BUBBLE;
      t1_exp[1] = {mem_word(32'h0), 32'h0};
      t1_exp[2] = BUBBLE;
      t1_exp[3] = {mem_word(32'h4), 32'h4};
      t1_exp[4] = BUBBLE;
      t1_exp[5] = {mem_word(32'h8), 32'h8};
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("t1_seq", prev_bus, t1_exp[i]);
      end

      // stall while pc=8 is on the bus; next response goes to skid
      stall_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("t2_hold", prev_bus, {mem_word(32'h8), 32'h8});
         chk("t2_req_low", 64'(imem_req), 64'(1'b0));
      end
      stall_i = 1'b0;
      cyc();
      chk("t2_skid_out", prev_bus, {mem_word(32'hC), 32'hC});

      // redirect while in WAIT kills the outstanding response
      rsp_lat = 3;
      wait_req(1'b0, "t3_wait");
      br_taken_i  = 1'b1;
      br_target_i = 32'h0000_0103;
      cyc();
      rsp_lat = 1;
      chk("t3_kill_noreq", 64'(imem_req), 64'(1'b0));
      wait_req(1'b1, "t3_req");
      chk("t3_addr", 64'(imem_addr), 64'h100);
      wait_inst(32'h100, "t3_first_pc");

      // redirect together with a response while stalled
      wait_req(1'b1, "t4_req");
      cyc();
      br_taken_i  = 1'b1;
      br_target_i = 32'h0000_0200;
      stall_i     = 1'b1;
      cyc();
      chk("t4_req", 64'(imem_req), 64'(1'b1));
      chk("t4_addr", 64'(imem_addr), 64'h200);
      repeat (2) cyc();
      stall_i = 1'b0;
      wait_inst(32'h200, "t4_first_pc");

      // grant withheld for three cycles
      wait_req(1'b0, "t5_wait");
      gnt_delay = 3;
      wait_req(1'b1, "t5_req");
      a0 = imem_addr;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t5_req_held", 64'(imem_req), 64'(1'b1));
         chk("t5_addr_stable", 64'(imem_addr), 64'(a0));
         chk("t5_bubble", prev_bus, BUBBLE);
      end
      gnt_delay = 0;
      wait_inst(a0, "t5_pc");

      // reset in WAIT, late response must be ignored
      wait_req(1'b0, "t6_wait");
      rsp_lat = 3;
      wait_req(1'b1, "t6_req");
      cyc();
      rst = 1'b1;
      cyc();
      rst     = 1'b0;
      rsp_lat = 1;
      chk("t6_kill_noreq", 64'(imem_req), 64'(1'b0));
      wait_inst(RESET_PC, "t6_first_pc");

      // randomized stall / redirect / memory timing
      rand_mem = 1'b1;
      c0       = consumed;
      for (int i = 0; i < 3000; i++) begin
         stall_i = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 15) == 0) begin
            br_taken_i  = 1'b1;
            br_target_i = ($urandom_range(0, 3) == 0) ?
                          (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
         end
         cyc();
      end
      stall_i  = 1'b0;
      rand_mem = 1'b0;
      repeat (20) cyc();
      chk("rand_progress", 64'(consumed - c0 >= 50), 64'(1'b1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
